conv_cntrl_lb_seq: RTL and testbench

Input sequencer for the convolution line buffer. It accepts the raw pixel stream (valid/ready with sof/eol), drives the line buffer's push/pop/sof/eol/dat controls, and gates pops until a previous row exists. It takes the line buffer's previous-row pixel (`colD`) back in, aligns it against a matching delayed copy of the current-row pixel, and presents {current, previous} pixel pairs downstream under valid/ready. It also checks line width and frame framing.

---
 rtl/conv_pkg.sv | 7 +
 rtl/conv_cntrl_lb_seq.sv | 188 ++++++++++++++++++
 tb/tb_conv_cntrl_lb_seq.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared sizing for the convolution datapath.
// No logic; constants only.
// Defaults can be overridden per instance.
package conv_pkg;
    localparam int PIXEL_W     = 8;
    localparam int IMAGE_MAX_W = 64;
endpackage

// File: rtl/conv_cntrl_lb_seq.sv
// Line-buffer input sequencer: drives push/pop, aligns colD with the current pixel, emits {cur, prv} pairs.
// Latency: a pixel pushed on beat j is presented on out_* the cycle after pushed beat j+2.
// Backpressure: out_vld_o & ~out_rdy_i drops in_rdy_o combinationally; no push means pipe and line buffer stall together.
module conv_cntrl_lb_seq #(
    parameter int PIXEL_W     = conv_pkg::PIXEL_W,
    parameter int IMAGE_MAX_W = conv_pkg::IMAGE_MAX_W
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               in_vld_i,
    output logic               in_rdy_o,
    input  logic [PIXEL_W-1:0] in_dat_i,
    input  logic               in_sof_i,
    input  logic               in_eol_i,
    output logic               lb_push_o,
    output logic               lb_pop_o,
    output logic [PIXEL_W-1:0] lb_dat_o,
    output logic               lb_sof_o,
    output logic               lb_eol_o,
    input  logic [PIXEL_W-1:0] colD_i,
    output logic               out_vld_o,
    input  logic               out_rdy_i,
    output logic [PIXEL_W-1:0] out_cur_o,
    output logic [PIXEL_W-1:0] out_prv_o,
    output logic               out_prv_vld_o,
    output logic               out_sof_o,
    output logic               out_eol_o,
    output logic               err_o
);

    localparam int COL_W = (IMAGE_MAX_W > 1) ? $clog2(IMAGE_MAX_W) : 1;
    localparam int WID_W = $clog2(IMAGE_MAX_W + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_MAX_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW0 = 2'd1,
        ROWN = 2'd2
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic prv_vld;
    } tag_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [WID_W-1:0]   width_q, width_d;
    logic               err_q, err_d;
    logic               s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d;
    tag_t               s0_tag_q, s0_tag_d, s1_tag_q, s1_tag_d;
    logic [PIXEL_W-1:0] s0_dat_q, s1_dat_q;
    logic               out_vld_q, out_vld_d;
    tag_t               out_tag_q, out_tag_d;
    logic [PIXEL_W-1:0] out_cur_q, out_prv_q;

    logic               acc, push, pop, eol_eff, at_last, out_load;
    state_t             st_eff;
    logic [COL_W-1:0]   col_eff;
    logic [WID_W-1:0]   col_eff_p1;
    tag_t               beat_tag;

    // A sof beat is treated as column 0 of a fresh first row regardless of where we were.
    assign in_rdy_o   = ~out_vld_q | out_rdy_i;
    assign acc        = in_vld_i & in_rdy_o;
    assign st_eff     = in_sof_i ? ROW0 : state_q;
    assign col_eff    = in_sof_i ? '0 : col_q;
    assign col_eff_p1 = WID_W'(col_eff) + WID_W'(1);
    assign at_last    = (col_eff == COL_LAST);
    assign eol_eff    = in_eol_i | at_last;
    // Beats before the first sof are swallowed: accepted but never reach the line buffer.
    assign push       = acc & (in_sof_i | (state_q != IDLE));
    // No pops until a previous row of this frame exists in the line buffer.
    assign pop        = push & (st_eff == ROWN);
    assign out_load   = push & s1_vld_q;
    assign beat_tag   = {in_sof_i, eol_eff, (st_eff == ROWN)};

    assign lb_push_o  = push;
    assign lb_pop_o   = pop;
    assign lb_dat_o   = in_dat_i;
    assign lb_sof_o   = in_sof_i & acc;
    assign lb_eol_o   = push & eol_eff;

    assign out_vld_o     = out_vld_q;
    assign out_cur_o     = out_cur_q;
    assign out_prv_o     = out_prv_q;
    assign out_prv_vld_o = out_tag_q.prv_vld;
    assign out_sof_o     = out_tag_q.sof;
    assign out_eol_o     = out_tag_q.eol;
    assign err_o         = err_q;

    // Next state: FSM, column/width tracking, error flag, alignment pipe and output handshake.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        width_d   = width_q;
        err_d     = err_q;
        s0_vld_d  = s0_vld_q;
        s1_vld_d  = s1_vld_q;
        s0_tag_d  = s0_tag_q;
        s1_tag_d  = s1_tag_q;
        out_vld_d = out_vld_q;
        out_tag_d = out_tag_q;

        if (out_vld_q & out_rdy_i) begin
            out_vld_d = 1'b0;
        end

        if (acc & ~push) begin
            err_d = 1'b1;
        end

        if (push) begin
            // Clear on sof first so any error detected on the same beat still lands.
            if (in_sof_i) begin
                err_d = 1'b0;
            end
            if ((st_eff == ROW0) && eol_eff) begin
                state_d = ROWN;
                width_d = col_eff_p1;
            end else begin
                state_d = st_eff;
            end
            col_d = eol_eff ? '0 : (col_eff + COL_W'(1));

            if (in_sof_i && (state_q != IDLE) && (col_q != '0)) begin
                err_d = 1'b1;
            end
            if ((st_eff == ROWN) && eol_eff && (col_eff_p1 != width_q)) begin
                err_d = 1'b1;
            end
            if (at_last && ~in_eol_i) begin
                err_d = 1'b1;
            end

            s0_vld_d = 1'b1;
            s0_tag_d = beat_tag;
            s1_vld_d = s0_vld_q;
            s1_tag_d = s0_tag_q;

            if (s1_vld_q) begin
                out_vld_d = 1'b1;
                out_tag_d = s1_tag_q;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            width_q   <= '0;
            err_q     <= 1'b0;
            s0_vld_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s0_tag_q  <= '0;
            s1_tag_q  <= '0;
            out_vld_q <= 1'b0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            width_q   <= width_d;
            err_q     <= err_d;
            s0_vld_q  <= s0_vld_d;
            s1_vld_q  <= s1_vld_d;
            s0_tag_q  <= s0_tag_d;
            s1_tag_q  <= s1_tag_d;
            out_vld_q <= out_vld_d;
            out_tag_q <= out_tag_d;
        end
    end

    // Pixel data path; qualified by the valids above, so left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            s0_dat_q <= in_dat_i;
            s1_dat_q <= s0_dat_q;
        end
        if (out_load) begin
            out_cur_q <= s1_dat_q;
            out_prv_q <= colD_i;
        end
    end

endmodule

// File: tb/tb_conv_cntrl_lb_seq.sv
module tb_conv_cntrl_lb_seq;

    localparam int PW = 8;
    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          in_vld_i = 1'b0;
    logic          in_rdy_o;
    logic [PW-1:0] in_dat_i = '0;
    logic          in_sof_i = 1'b0;
    logic          in_eol_i = 1'b0;
    logic          lb_push_o, lb_pop_o, lb_sof_o, lb_eol_o;
    logic [PW-1:0] lb_dat_o;
    logic [PW-1:0] colD_i = '0;
    logic          out_vld_o;
    logic          out_rdy_i = 1'b1;
    logic [PW-1:0] out_cur_o, out_prv_o;
    logic          out_prv_vld_o, out_sof_o, out_eol_o, err_o;

    conv_cntrl_lb_seq #(.PIXEL_W(PW), .IMAGE_MAX_W(MW)) dut (
        .clk(clk), .arst_n(arst_n),
        .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_dat_i(in_dat_i),
        .in_sof_i(in_sof_i), .in_eol_i(in_eol_i),
        .lb_push_o(lb_push_o), .lb_pop_o(lb_pop_o), .lb_dat_o(lb_dat_o),
        .lb_sof_o(lb_sof_o), .lb_eol_o(lb_eol_o), .colD_i(colD_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .out_cur_o(out_cur_o), .out_prv_o(out_prv_o), .out_prv_vld_o(out_prv_vld_o),
        .out_sof_o(out_sof_o), .out_eol_o(out_eol_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [PW-1:0] dat;
        logic [PW-1:0] prv;
        logic          sof;
        logic          eol;
        logic          prv_vld;
        logic          chk;
    } exp_t;

    exp_t          expq[$];
    logic [PW-1:0] lbq[$];
    logic [PW-1:0] pop_hist[0:4095];
    logic [PW-1:0] cur_row[0:MW-1];
    logic [PW-1:0] prv_row[0:MW-1];
    int            pcnt = 0, push_cnt = 0, pop_cnt = 0, out_cnt = 0;
    int            m_row = 0, m_col = 0;
    logic          sb_en = 1'b1;
    logic          rnd_rdy = 1'b0;

    // Monitor: line-buffer model, reference pair model and output scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!arst_n) begin
            expq.delete();
            lbq.delete();
            pcnt  = 0;
            m_row = 0;
            m_col = 0;
        end else begin
            if (out_vld_o && out_rdy_i) begin
                out_cnt++;
                if (expq.size() == 0) begin
                    check("sb_extra_pair", out_vld_o, 0);
                end else begin
                    e = expq.pop_front();
                    if (e.chk) begin
                        check("sb_cur", out_cur_o, e.dat);
                        check("sb_sof", out_sof_o, e.sof);
                        check("sb_eol", out_eol_o, e.eol);
                        check("sb_prv_vld", out_prv_vld_o, e.prv_vld);
                        if (e.prv_vld) check("sb_prv", out_prv_o, e.prv);
                    end
                end
            end
            if (lb_push_o) begin
                check("push_while_rdy", in_rdy_o, 1);
                check("lb_dat", lb_dat_o, in_dat_i);
                check("lb_sof", lb_sof_o, in_sof_i);
                push_cnt++;
                if (in_sof_i) begin
                    m_row = 0;
                    m_col = 0;
                    lbq.delete();
                end
                e.dat     = in_dat_i;
                e.sof     = in_sof_i;
                e.prv_vld = (m_row > 0);
                e.prv     = prv_row[m_col];
                e.eol     = in_eol_i || (m_col == MW - 1);
                e.chk     = sb_en;
                cur_row[m_col] = in_dat_i;
                if (e.eol) begin
                    prv_row = cur_row;
                    m_row++;
                    m_col = 0;
                end else begin
                    m_col++;
                end
                expq.push_back(e);
                if (lb_pop_o) begin
                    pop_cnt++;
                    pop_hist[pcnt & 4095] = (lbq.size() > 0) ? lbq.pop_front() : '0;
                end
                lbq.push_back(in_dat_i);
                pcnt++;
            end
        end
    end

    // Line buffer read port: value popped two pushes ago, stable until the next push.
    always @(posedge clk) begin
        #1;
        colD_i = (pcnt >= 2) ? pop_hist[(pcnt - 2) & 4095] : '0;
    end

    // Downstream ready: always ready, or a coin flip per cycle.
    always @(posedge clk) begin
        #1;
        out_rdy_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [PW-1:0] d, input logic s, input logic e, output logic eol_seen);
        int   n  = 0;
        logic ok = 1'b0;
        in_vld_i = 1'b1;
        in_dat_i = d;
        in_sof_i = s;
        in_eol_i = e;
        eol_seen = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok       = in_rdy_o;
            eol_seen = lb_eol_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("send_timeout", in_rdy_o, 1);
        in_vld_i = 1'b0;
        in_sof_i = 1'b0;
        in_eol_i = 1'b0;
    endtask

    task automatic send_line(input logic [PW-1:0] base, input int w, input logic sof);
        logic seen;
        for (int c = 0; c < w; c++)
            send(base + PW'(c), sof && (c == 0), (c == w - 1), seen);
    endtask

    task automatic send_frame(input logic [PW-1:0] base, input int rows, input int w);
        for (int r = 0; r < rows; r++)
            send_line(base + PW'(r * w), w, (r == 0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int   p0, q0, o0;
        logic seen;

        // Reset state
        tick(2);
        arst_n = 1'b1;
        tick(1);
        check("rst_in_rdy", in_rdy_o, 1);
        check("rst_out_vld", out_vld_o, 0);
        check("rst_out_sof", out_sof_o, 0);
        check("rst_out_eol", out_eol_o, 0);
        check("rst_out_prv_vld", out_prv_vld_o, 0);
        check("rst_err", err_o, 0);
        check("rst_lb_pop", lb_pop_o, 0);

        // Non-sof beats in IDLE are accepted, not pushed, and flag an error
        for (int i = 0; i < 3; i++) begin
            in_vld_i = 1'b1;
            in_dat_i = PW'(8'hF0 + i);
            in_sof_i = 1'b0;
            in_eol_i = (i == 2);
            #1;
            check("idle_rdy", in_rdy_o, 1);
            check("idle_push", lb_push_o, 0);
            tick(1);
            check("idle_err", err_o, 1);
        end
        in_vld_i = 1'b0;
        in_eol_i = 1'b0;

        // 2-line frame, width 4, continuous
        p0 = push_cnt; q0 = pop_cnt; o0 = out_cnt;
        send_frame(8'h10, 2, 4);
        check("f1_err_cleared", err_o, 0);
        tick(4);
        check("f1_push_cnt", push_cnt - p0, 8);
        check("f1_pop_cnt", pop_cnt - q0, 4);
        check("f1_pairs_before_tail", out_cnt - o0, 6);

        // 3-line width-8 frame with random downstream ready; its first two beats release the previous tail
        o0 = out_cnt;
        rnd_rdy = 1'b1;
        send_frame(8'h40, 3, 8);
        rnd_rdy = 1'b0;
        tick(4);
        check("f2_pairs", out_cnt - o0, 24);
        check("f2_err", err_o, 0);

        // Row 1 one pixel wider than row 0
        sb_en = 1'b0;
        send_line(8'h80, 4, 1'b1);
        for (int c = 0; c < 4; c++) send(8'h90 + PW'(c), 1'b0, 1'b0, seen);
        check("wide_err_before_eol", err_o, 0);
        send(8'h94, 1'b0, 1'b1, seen);
        check("wide_err_at_eol", err_o, 1);
        send_line(8'hA0, 4, 1'b0);
        check("wide_err_held", err_o, 1);

        // Line of IMAGE_MAX_W+2 and beyond without eol: forced eol every IMAGE_MAX_W beats
        for (int i = 0; i < 2 * MW + 2; i++) begin
            send(PW'(i), (i == 0), 1'b0, seen);
            check("forced_eol", seen, (i == MW - 1) || (i == 2 * MW - 1));
            if (i == 0)      check("sof_clears_err", err_o, 0);
            if (i == MW - 2) check("err_before_force", err_o, 0);
            if (i == MW - 1) check("err_on_force", err_o, 1);
        end

        // Reset in the middle of row 1, then a fresh frame
        sb_en = 1'b1;
        send_line(8'hB0, 4, 1'b1);
        send(8'hB4, 1'b0, 1'b0, seen);
        send(8'hB5, 1'b0, 1'b0, seen);
        arst_n = 1'b0;
        #1;
        check("mid_rst_out_vld", out_vld_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_prv_vld", out_prv_vld_o, 0);
        check("mid_rst_in_rdy", in_rdy_o, 1);
        tick(2);
        arst_n = 1'b1;
        tick(1);
        o0 = out_cnt;
        send_frame(8'hC0, 2, 4);
        send_line(8'hE0, 2, 1'b1);
        tick(4);
        check("post_rst_pairs", out_cnt - o0, 8);
        check("post_rst_tail_left", expq.size(), 2);
        check("post_rst_err", err_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
